dma_cfg_initiator: RTL

//  Bus initiator that programs one DMA channel's register block over the valid/wr_en/addr/wdata/rdata bus.

---
 rtl/dma_cfg_pkg.sv | 28 ++
 rtl/dma_cfg_initiator_if.sv | 15 +
 rtl/dma_cfg_rdcheck.sv | 31 +++
 rtl/dma_cfg_initiator.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dma_cfg_pkg.sv
// Shared constants for the DMA channel programming initiator: register offsets,
// FSM state encoding and the fixed write/readback beat order.
package dma_cfg_pkg;

  localparam logic [7:0] INTR_OFS     = 8'h00;
  localparam logic [7:0] CONTROL_OFS  = 8'h04;
  localparam logic [7:0] IO_ADDR_OFS  = 8'h08;
  localparam logic [7:0] MEM_ADDR_OFS = 8'h0C;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    DONE    = 3'd4
  } cfg_state_e;

  // Control goes last because writing it arms the channel.
  function automatic logic [7:0] beat_ofs(input logic [1:0] idx);
    case (idx)
      2'd0:    return IO_ADDR_OFS;
      2'd1:    return MEM_ADDR_OFS;
      2'd2:    return INTR_OFS;
      default: return CONTROL_OFS;
    endcase
  endfunction

endpackage

// File: rtl/dma_cfg_initiator_if.sv
// Simple register bus between the DMA programming initiator and the channel
// register block: one strobe, a write enable, address and both data paths.
interface dma_cfg_initiator_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  valid;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output valid, wr_en, addr, wdata, input rdata);
  modport slave  (input valid, wr_en, addr, wdata, output rdata);
endinterface

// File: rtl/dma_cfg_rdcheck.sv
// Readback comparator with a sticky error flag; remembers only the address of
// the first mismatching register of a job.
module dma_cfg_rdcheck #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  chk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [DATA_WIDTH-1:0] exp_data,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (clr) begin
      err      <= 1'b0;
      err_addr <= '0;
    end else if (chk && !err && (rdata != exp_data)) begin
      err      <= 1'b1;
      err_addr <= addr;
    end
  end

endmodule

// File: rtl/dma_cfg_initiator.sv
// Programs one DMA channel register block from a ready/valid job.
// Readback checking is built only when DMA_CFG_READBACK_EN is defined.
//
// state   | meaning
// IDLE    | job_ready=1, waiting for a job
// WRITE   | four write beats, one per cycle
// RD_REQ  | single-cycle read strobe for the current beat
// RD_WAIT | RD_LAT idle cycles, rdata compared on the last one
// DONE    | one-cycle done pulse, bus idle
module dma_cfg_initiator
  import dma_cfg_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h400,
  parameter int unsigned           RD_LAT     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [DATA_WIDTH-1:0]  job_intr,
  input  logic [DATA_WIDTH-1:0]  job_control,
  input  logic [DATA_WIDTH-1:0]  job_io_addr,
  input  logic [DATA_WIDTH-1:0]  job_mem_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [ADDR_WIDTH-1:0]  err_addr,
  dma_cfg_initiator_if.master    bus
);

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_WRITE   = WRITE;
  localparam logic [2:0] ST_DONE    = DONE;
`ifdef DMA_CFG_READBACK_EN
  localparam logic [2:0] ST_RD_REQ  = RD_REQ;
  localparam logic [2:0] ST_RD_WAIT = RD_WAIT;
`endif

  logic [2:0]            state;
  logic [1:0]            beat;
  logic [1:0]            next_beat;
  logic                  accept;
  logic [DATA_WIDTH-1:0] snap_intr;
  logic [DATA_WIDTH-1:0] snap_control;
  logic [DATA_WIDTH-1:0] snap_io;
  logic [DATA_WIDTH-1:0] snap_mem;
  logic [DATA_WIDTH-1:0] next_word;
`ifdef DMA_CFG_READBACK_EN
  logic [1:0]            lat_cnt;
`endif

  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [1:0] idx);
    return BASE_ADDR + ADDR_WIDTH'(beat_ofs(idx));
  endfunction

  assign job_ready = (state == ST_IDLE);
  assign accept    = job_ready & job_valid;
  assign next_beat = beat + 2'd1;

  always_comb begin
    next_word = snap_io;
    case (next_beat)
      2'd1:    next_word = snap_mem;
      2'd2:    next_word = snap_intr;
      2'd3:    next_word = snap_control;
      default: next_word = snap_io;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      beat         <= 2'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      bus.valid    <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.addr     <= '0;
      bus.wdata    <= '0;
      snap_intr    <= '0;
      snap_control <= '0;
      snap_io      <= '0;
      snap_mem     <= '0;
`ifdef DMA_CFG_READBACK_EN
      lat_cnt      <= 2'd0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            snap_intr    <= job_intr;
            snap_control <= job_control;
            snap_io      <= job_io_addr;
            snap_mem     <= job_mem_addr;
            state        <= ST_WRITE;
            beat         <= 2'd0;
            busy         <= 1'b1;
            // First beat comes straight from the job port; the snapshot lands this same edge.
            bus.valid    <= 1'b1;
            bus.wr_en    <= 1'b1;
            bus.addr     <= beat_addr(2'd0);
            bus.wdata    <= job_io_addr;
          end
        end
        ST_WRITE: begin
          if (beat != 2'd3) begin
            beat      <= next_beat;
            bus.addr  <= beat_addr(next_beat);
            bus.wdata <= next_word;
          end else begin
`ifdef DMA_CFG_READBACK_EN
            state     <= ST_RD_REQ;
            beat      <= 2'd0;
            bus.wr_en <= 1'b0;
            bus.addr  <= beat_addr(2'd0);
`else
            state     <= ST_DONE;
            bus.valid <= 1'b0;
            bus.wr_en <= 1'b0;
            done      <= 1'b1;
`endif
          end
        end
`ifdef DMA_CFG_READBACK_EN
        ST_RD_REQ: begin
          bus.valid <= 1'b0;
          lat_cnt   <= 2'(RD_LAT - 1);
          state     <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (lat_cnt != 2'd0) begin
            lat_cnt <= lat_cnt - 2'd1;
          end else if (beat != 2'd3) begin
            beat      <= next_beat;
            bus.valid <= 1'b1;
            bus.addr  <= beat_addr(next_beat);
            state     <= ST_RD_REQ;
          end else begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
`endif
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          bus.valid <= 1'b0;
          bus.wr_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMA_CFG_READBACK_EN
  logic                  rd_chk;
  logic [DATA_WIDTH-1:0] cur_word;

  // Address still holds the read address during RD_WAIT, so it doubles as err_addr source.
  assign rd_chk = (state == ST_RD_WAIT) && (lat_cnt == 2'd0);

  always_comb begin
    cur_word = snap_io;
    case (beat)
      2'd1:    cur_word = snap_mem;
      2'd2:    cur_word = snap_intr;
      2'd3:    cur_word = snap_control;
      default: cur_word = snap_io;
    endcase
  end

  dma_cfg_rdcheck #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rdcheck (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept),
    .chk      (rd_chk),
    .addr     (bus.addr),
    .rdata    (bus.rdata),
    .exp_data (cur_word),
    .err      (err),
    .err_addr (err_addr)
  );
`else
  logic unused_rdata;

  assign err          = 1'b0;
  assign err_addr     = '0;
  assign unused_rdata = ^{bus.rdata, (RD_LAT > 4)};
`endif

endmodule
